mdu_unit: RTL
=============

Name: mdu_unit

Overview:
- Multiply/divide unit in the EX stage, beside the ALU.
- Takes the same forwarded A/B operands as the ALU and owns the architectural HI/LO registers.
- Its read-out (HI or LO) is muxed with the ALU Result into the EX/MEM pipeline register.
- Multi-cycle operations raise Busy. The hazard controller uses Busy to stall later MDU instructions.

Parameters:
- MULT_CYCLES, default 5: number of cycles Busy stays high for mult/multu. Must be ≥1.
- DIV_CYCLES, default 10: number of cycles Busy stays high for div/divu. Must be ≥1.

Ports:
- clk, input, 1: rising-edge clock.
- reset, input, 1: asynchronous, active-low. 0 clears all state immediately.
- Start, input, 1: one-cycle strobe. Valid MduOp/A/B are present this cycle.
- MduOp, input, 3: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (no effect).
- A, input, 32: forwarded rs operand (dividend / multiplicand / mt source).
- B, input, 32: forwarded rt operand (divisor / multiplier).
- ReadSel, input, 1: 0 selects LO, 1 selects HI.
- Busy, output, 1: a mult/div operation is in progress.
- HI, output, 32: architectural HI register.
- LO, output, 32: architectural LO register.
- Result, output, 32: combinational. Equals HI when ReadSel=1, otherwise LO (mfhi/mflo path).

Behaviour:
- Reset (reset=0, asynchronous): HI=0, LO=0, Busy=0, countdown=0, shadow registers=0. Result follows ReadSel over the cleared HI/LO.
- Reset during an operation aborts it; nothing is committed.
- State machine, 2 states:
  - IDLE: countdown=0, Busy=0.
  - RUN: countdown≠0, Busy=1.
- IDLE with Start=1 and MduOp in {1..4}, at edge k:
  - Compute the full result from A/B and latch it into shadow_hi/shadow_lo.
  - Load countdown with MULT_CYCLES (ops 1,2) or DIV_CYCLES (ops 3,4).
  - Enter RUN.
- RUN:
  - Each edge decrements countdown.
  - At the edge where countdown goes 1→0: HI←shadow_hi, LO←shadow_lo, return to IDLE.
  - Busy is therefore high for exactly N cycles (edges k+1..k+N). New HI/LO are visible from cycle k+N onward, the same cycle Busy falls.
- mthi (5) / mtlo (6) with Start=1 in IDLE: HI (or LO) ←A at that edge. Single cycle; Busy stays 0.
- Start=1 while Busy=1: ignored entirely, including mthi/mtlo. The in-flight operation is unaffected. The controller is required to stall while Start|Busy, so this case indicates a controller bug; the bench flags it.
- Start=1 with MduOp 0 or 7: no effect.
- Arithmetic:
  - mult: signed 32×32→64. HI=product[63:32], LO=product[31:0].
  - multu: unsigned 32×32→64, same split.
  - div: signed. LO=quotient truncated toward zero; HI=remainder with the sign of the dividend.
  - div overflow: 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
  - divu: unsigned. LO=quotient, HI=remainder.
  - B=0 (div or divu): the operation still runs the full DIV_CYCLES, but HI/LO are left unchanged at completion.
- Result is purely combinational from HI/LO/ReadSel. It does not reflect shadow values while Busy.

Decomposition:
- Shared package (mdu_pkg) holds:
  - MduOp encodings: MDU_NONE, MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU, MDU_MTHI, MDU_MTLO.
  - ReadSel encodings: SEL_LO, SEL_HI.
  - Default cycle constants.
- The decoder and hazard unit import the same package.
- One natural sub-module: mdu_arith. It is combinational and maps MduOp/A/B to {shadow_hi, shadow_lo, div_by_zero}.
- The top holds the countdown, Busy, and the HI/LO registers.

Test Plan:
- Reset then multu: hold reset=0, then release. Expect HI=LO=0, Busy=0. Start multu A=0xFFFFFFFF B=2. Expect Busy=1 for exactly 5 cycles, then HI=0x00000001, LO=0xFFFFFFFE, Busy=0.
- Signed mult: A=-3 (0xFFFFFFFD), B=7. After 5 cycles expect HI=0xFFFFFFFF, LO=0xFFFFFFEB. Result with ReadSel=0 equals 0xFFFFFFEB, and with ReadSel=1 equals 0xFFFFFFFF.
- Division and edge cases:
  - div A=-7, B=2: after 10 cycles expect LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - divu A=7, B=2: expect LO=3, HI=1.
  - div A=0x80000000, B=0xFFFFFFFF: expect LO=0x80000000, HI=0.
- Divide by zero: preset HI=0x11, LO=0x22 via mthi/mtlo. Then div A=5, B=0. Expect Busy high 10 cycles, and HI=0x11, LO=0x22 afterwards.
- Start while busy: start mult A=2, B=3. At cycle 2 pulse Start with mtlo A=0xDEAD. Expect the mtlo to be ignored, and after completion HI=0, LO=6.
- Reset mid-operation: start div A=100, B=10. Assert reset=0 at cycle 4. Expect Busy=0, HI=LO=0 immediately (asynchronously), and no commit after reset is released.

Source files
------------

// File: rtl/mdu_pkg.sv
// =============================================================================
// Module      : mdu_pkg
// Description : Shared encodings and defaults for the multiply/divide unit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTHI  = 3'd5;
    localparam logic [2:0] MDU_MTLO  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    localparam logic SEL_LO = 1'b0;
    localparam logic SEL_HI = 1'b1;

    localparam int DEF_MULT_CYCLES = 5;
    localparam int DEF_DIV_CYCLES  = 10;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_div_op(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// =============================================================================
// Module      : mdu_arith
// Description : Combinational 32x32 multiply and divide producing HI/LO values.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mdu_arith
    import mdu_pkg::*;
(
    input  logic [2:0]  MduOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic [31:0] shadow_hi,
    output logic [31:0] shadow_lo,
    output logic        div_by_zero
);

    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_bs_safe;
    logic [31:0] w_bu_safe;
    logic [31:0] w_sq;
    logic [31:0] w_sr;
    logic [31:0] w_uq;
    logic [31:0] w_ur;

    // Low 64 bits of a 64x64 product of sign-extended operands is the signed product.
    assign w_prod_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    assign w_prod_u = {32'd0, A} * {32'd0, B};

    // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
    assign w_a_neg   = A[31];
    assign w_b_neg   = B[31];
    assign w_a_mag   = w_a_neg ? (32'd0 - A) : A;
    assign w_b_mag   = w_b_neg ? (32'd0 - B) : B;
    assign w_bs_safe = (w_b_mag == 32'd0) ? 32'd1 : w_b_mag;
    assign w_bu_safe = (B == 32'd0) ? 32'd1 : B;
    assign w_sq      = w_a_mag / w_bs_safe;
    assign w_sr      = w_a_mag % w_bs_safe;
    assign w_uq      = A / w_bu_safe;
    assign w_ur      = A % w_bu_safe;

    always_comb begin
        shadow_hi   = 32'd0;
        shadow_lo   = 32'd0;
        div_by_zero = is_div_op(MduOp) && (B == 32'd0);
        case (MduOp)
            MDU_MULT: begin
                shadow_hi = w_prod_s[63:32];
                shadow_lo = w_prod_s[31:0];
            end
            MDU_MULTU: begin
                shadow_hi = w_prod_u[63:32];
                shadow_lo = w_prod_u[31:0];
            end
            MDU_DIV: begin
                shadow_lo = (w_a_neg ^ w_b_neg) ? (32'd0 - w_sq) : w_sq;
                shadow_hi = w_a_neg ? (32'd0 - w_sr) : w_sr;
            end
            MDU_DIVU: begin
                shadow_lo = w_uq;
                shadow_hi = w_ur;
            end
            default: begin
                shadow_hi = 32'd0;
                shadow_lo = 32'd0;
            end
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// =============================================================================
// Module      : mdu_unit
// Description : EX-stage multiply/divide unit owning HI/LO with a fixed-latency
//               busy window before results commit.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MULT_CYCLES = DEF_MULT_CYCLES,
    parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start,
    input  logic [2:0]  MduOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        ReadSel,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] Result
);

    localparam int c_MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int c_CNT_W      = $clog2(c_MAX_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MULT_LOAD = c_CNT_W'(MULT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_DIV_LOAD  = c_CNT_W'(DIV_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    mdu_state_e         r_state;
    logic [c_CNT_W-1:0] r_count;
    logic               r_busy;
    logic [31:0]        r_hi;
    logic [31:0]        r_lo;
    logic [31:0]        r_shadow_hi;
    logic [31:0]        r_shadow_lo;
    logic               r_shadow_dz;

    logic [31:0]        w_arith_hi;
    logic [31:0]        w_arith_lo;
    logic               w_arith_dz;

    mdu_arith u_arith (
        .MduOp       (MduOp),
        .A           (A),
        .B           (B),
        .shadow_hi   (w_arith_hi),
        .shadow_lo   (w_arith_lo),
        .div_by_zero (w_arith_dz)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_count     <= '0;
            r_busy      <= 1'b0;
            r_hi        <= 32'd0;
            r_lo        <= 32'd0;
            r_shadow_hi <= 32'd0;
            r_shadow_lo <= 32'd0;
            r_shadow_dz <= 1'b0;
        end else if (r_state == ST_IDLE) begin
            if (Start) begin
                case (MduOp)
                    MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        r_shadow_hi <= w_arith_hi;
                        r_shadow_lo <= w_arith_lo;
                        r_shadow_dz <= w_arith_dz;
                        r_count     <= is_div_op(MduOp) ? c_DIV_LOAD : c_MULT_LOAD;
                        r_busy      <= 1'b1;
                        r_state     <= ST_RUN;
                    end
                    MDU_MTHI: r_hi <= A;
                    MDU_MTLO: r_lo <= A;
                    default: ;
                endcase
            end
        end else begin
            // Start is deliberately not looked at here: the hazard unit must stall.
            if (r_count == c_ONE) begin
                if (!r_shadow_dz) begin
                    r_hi <= r_shadow_hi;
                    r_lo <= r_shadow_lo;
                end
                r_count <= '0;
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
            end else begin
                r_count <= r_count - c_ONE;
            end
        end
    end

    assign Busy   = r_busy;
    assign HI     = r_hi;
    assign LO     = r_lo;
    assign Result = (ReadSel == SEL_HI) ? r_hi : r_lo;

endmodule

`default_nettype wire
